// File: rtl/csr_load_phase_ctrl.sv
// ----------------------------------------------------------------------------
// csr_load_phase_ctrl
//
// Phase controller for the CSR sparse-matrix datapath. It owns the ports of
// the value RAM, the column RAM and the row-pointer RAM.
//   LOAD    : a handshaked beat stream is written into the RAMs. Kind-0 beats
//             go to value/column, and kind-1 beats go to the row pointers.
//   COMPUTE : RAM addresses come from the multiply engine, and writes are off.
//   DONE    : the matrix is kept. It can be re-run or replaced.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ld_start              request to load a new matrix (IDLE/DONE only)
//   ld_valid/ld_ready     load beat handshake
//   ld_kind/val/col/last  beat payload
//   eng_vc_addr/row_addr  engine read addresses (used in COMPUTE/DONE)
//   eng_done, eng_rerun   engine pass finished / request another pass
//   eng_start             one-cycle engine start pulse
//   mem_*                 RAM address / write enable / write data
//   nnz_count, row_count  entries stored in each RAM
//   phase                 IDLE=0, LOAD=1, COMPUTE=2, DONE=3 (FSM state)
//   done                  high while phase==DONE
//   err_overflow          sticky: a beat was dropped for lack of capacity
//
// Handshake: a beat transfers in every cycle where ld_valid & ld_ready are
// both high. ld_ready depends only on the phase, never on ld_valid. The write
// for a beat happens in its transfer cycle.
// ----------------------------------------------------------------------------
module csr_load_phase_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 14,
    parameter int ROW_W     = 10,
    parameter int NNZ_DEPTH = 16384,
    parameter int ROW_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_kind,
    input  logic [DATA_W-1:0] ld_val,
    input  logic [DATA_W-1:0] ld_col,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] eng_vc_addr,
    input  logic [ROW_W-1:0]  eng_row_addr,
    input  logic              eng_done,
    input  logic              eng_rerun,
    output logic              eng_start,
    output logic [ADDR_W-1:0] mem_vc_addr,
    output logic              mem_vc_we,
    output logic [DATA_W-1:0] mem_val_din,
    output logic [DATA_W-1:0] mem_col_din,
    output logic [ROW_W-1:0]  mem_row_addr,
    output logic              mem_row_we,
    output logic [DATA_W-1:0] mem_row_din,
    output logic [ADDR_W:0]   nnz_count,
    output logic [ROW_W:0]    row_count,
    output logic [1:0]        phase,
    output logic              done,
    output logic              err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DONE    = 2'd3
    } phase_t;

    localparam logic [ADDR_W:0] NNZ_LIM = (ADDR_W+1)'(NNZ_DEPTH);
    localparam logic [ROW_W:0]  ROW_LIM = (ROW_W+1)'(ROW_DEPTH);

    phase_t            r_phase;
    logic [ADDR_W:0]   r_nnz;
    logic [ROW_W:0]    r_row;
    logic              r_err;
    logic              r_eng_start;

    logic              w_accept;
    logic              w_vc_full;
    logic              w_row_full;
    logic              w_use_counters;

    assign w_accept       = (r_phase == S_LOAD) && ld_valid;
    assign w_vc_full      = (r_nnz == NNZ_LIM);
    assign w_row_full     = (r_row == ROW_LIM);
    assign w_use_counters = (r_phase == S_IDLE) || (r_phase == S_LOAD);

    // A full RAM still accepts its beat, so the stream never stalls. The
    // beat is only not written.
    assign ld_ready     = (r_phase == S_LOAD);
    assign mem_vc_we    = w_accept && !ld_kind && !w_vc_full;
    assign mem_row_we   = w_accept &&  ld_kind && !w_row_full;
    assign mem_vc_addr  = w_use_counters ? r_nnz[ADDR_W-1:0] : eng_vc_addr;
    assign mem_row_addr = w_use_counters ? r_row[ROW_W-1:0]  : eng_row_addr;
    assign mem_val_din  = ld_val;
    assign mem_col_din  = ld_col;
    assign mem_row_din  = ld_val;

    assign eng_start    = r_eng_start;
    assign nnz_count    = r_nnz;
    assign row_count    = r_row;
    assign phase        = r_phase;
    assign done         = (r_phase == S_DONE);
    assign err_overflow = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= S_IDLE;
            r_nnz       <= '0;
            r_row       <= '0;
            r_err       <= 1'b0;
            r_eng_start <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_phase)
                S_IDLE: begin
                    if (ld_start) begin
                        r_phase <= S_LOAD;
                        r_nnz   <= '0;
                        r_row   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        if (!ld_kind) begin
                            if (w_vc_full) r_err <= 1'b1;
                            else           r_nnz <= r_nnz + 1'b1;
                        end else begin
                            if (w_row_full) r_err <= 1'b1;
                            else            r_row <= r_row + 1'b1;
                        end
                        if (ld_last) begin
                            r_phase     <= S_COMPUTE;
                            r_eng_start <= 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    // eng_done is honoured even in the eng_start cycle.
                    if (eng_done) r_phase <= S_DONE;
                end
                S_DONE: begin
                    // A new load has priority over a re-run.
                    if (ld_start) begin
                        r_phase <= S_LOAD;
                        r_nnz   <= '0;
                        r_row   <= '0;
                        r_err   <= 1'b0;
                    end else if (eng_rerun) begin
                        r_phase     <= S_COMPUTE;
                        r_eng_start <= 1'b1;
                    end
                end
                default: r_phase <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_load_phase_ctrl.sv
// Bench for csr_load_phase_ctrl. It runs directed sequences from the test
// plan and then randomized traffic. Every cycle is checked against a
// reference model that works at the level of phases and counters. Writes go
// through expected-write queues.
module tb_csr_load_phase_ctrl;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 14;
    localparam int ROW_W     = 10;
    localparam int NNZ_DEPTH = 4;
    localparam int ROW_DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              ld_start, ld_valid, ld_ready, ld_kind, ld_last;
    logic [DATA_W-1:0] ld_val, ld_col;
    logic [ADDR_W-1:0] eng_vc_addr;
    logic [ROW_W-1:0]  eng_row_addr;
    logic              eng_done, eng_rerun, eng_start;
    logic [ADDR_W-1:0] mem_vc_addr;
    logic              mem_vc_we, mem_row_we;
    logic [DATA_W-1:0] mem_val_din, mem_col_din, mem_row_din;
    logic [ROW_W-1:0]  mem_row_addr;
    logic [ADDR_W:0]   nnz_count;
    logic [ROW_W:0]    row_count;
    logic [1:0]        phase;
    logic              done, err_overflow;

    csr_load_phase_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W),
        .NNZ_DEPTH(NNZ_DEPTH), .ROW_DEPTH(ROW_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_kind(ld_kind), .ld_val(ld_val), .ld_col(ld_col), .ld_last(ld_last),
        .eng_vc_addr(eng_vc_addr), .eng_row_addr(eng_row_addr),
        .eng_done(eng_done), .eng_rerun(eng_rerun), .eng_start(eng_start),
        .mem_vc_addr(mem_vc_addr), .mem_vc_we(mem_vc_we),
        .mem_val_din(mem_val_din), .mem_col_din(mem_col_din),
        .mem_row_addr(mem_row_addr), .mem_row_we(mem_row_we),
        .mem_row_din(mem_row_din),
        .nnz_count(nnz_count), .row_count(row_count),
        .phase(phase), .done(done), .err_overflow(err_overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase numbers follow the externally visible encoding 0..3.
    int m_phase = 0;
    int m_nnz   = 0;
    int m_row   = 0;
    bit m_err   = 0;
    bit m_start = 0;

    // Scoreboard: the model pushes each write it expects. Each DUT write
    // pops one entry.
    logic [ADDR_W+2*DATA_W-1:0] vc_q[$];
    logic [ROW_W+DATA_W-1:0]    row_q[$];

    task automatic model_step();
        int  n_phase = m_phase;
        bit  n_start = 0;
        if (reset) begin
            m_phase = 0; m_nnz = 0; m_row = 0; m_err = 0; m_start = 0;
            return;
        end
        if ((m_phase == 0 || m_phase == 3) && ld_start) begin
            n_phase = 1; m_nnz = 0; m_row = 0; m_err = 0;
        end else if (m_phase == 1 && ld_valid) begin
            if (!ld_kind) begin
                if (m_nnz < NNZ_DEPTH) m_nnz++; else m_err = 1;
            end else begin
                if (m_row < ROW_DEPTH) m_row++; else m_err = 1;
            end
            if (ld_last) begin n_phase = 2; n_start = 1; end
        end else if (m_phase == 2 && eng_done) begin
            n_phase = 3;
        end else if (m_phase == 3 && eng_rerun) begin
            n_phase = 2; n_start = 1;
        end
        m_phase = n_phase;
        m_start = n_start;
    endtask

    // Called with inputs set just after a falling edge. It checks all
    // outputs, clocks once and advances the model.
    task automatic tick();
        bit                          acc, e_vc_we, e_row_we;
        logic [ADDR_W-1:0]           e_vc_addr;
        logic [ROW_W-1:0]            e_row_addr;
        logic [ADDR_W+2*DATA_W-1:0]  ve;
        logic [ROW_W+DATA_W-1:0]     re;
        #1;
        acc        = (m_phase == 1) && ld_valid;
        e_vc_we    = acc && !ld_kind && (m_nnz < NNZ_DEPTH);
        e_row_we   = acc &&  ld_kind && (m_row < ROW_DEPTH);
        e_vc_addr  = (m_phase < 2) ? ADDR_W'(m_nnz) : eng_vc_addr;
        e_row_addr = (m_phase < 2) ? ROW_W'(m_row)  : eng_row_addr;

        check("phase",        64'(phase),        64'(m_phase));
        check("done",         64'(done),         64'(m_phase == 3));
        check("ld_ready",     64'(ld_ready),     64'(m_phase == 1));
        check("eng_start",    64'(eng_start),    64'(m_start));
        check("nnz_count",    64'(nnz_count),    64'(m_nnz));
        check("row_count",    64'(row_count),    64'(m_row));
        check("err_overflow", 64'(err_overflow), 64'(m_err));
        check("mem_vc_we",    64'(mem_vc_we),    64'(e_vc_we));
        check("mem_row_we",   64'(mem_row_we),   64'(e_row_we));
        check("mem_vc_addr",  64'(mem_vc_addr),  64'(e_vc_addr));
        check("mem_row_addr", 64'(mem_row_addr), 64'(e_row_addr));

        if (e_vc_we)  vc_q.push_back({e_vc_addr, ld_val, ld_col});
        if (e_row_we) row_q.push_back({e_row_addr, ld_val});
        if (mem_vc_we === 1'b1) begin
            if (vc_q.size() == 0) check("vc_unexpected_write", 64'(1), 64'(0));
            else begin
                ve = vc_q.pop_front();
                check("vc_wr_addr", 64'(mem_vc_addr), 64'(ve[ADDR_W+2*DATA_W-1 -: ADDR_W]));
                check("vc_wr_val",  64'(mem_val_din), 64'(ve[2*DATA_W-1 -: DATA_W]));
                check("vc_wr_col",  64'(mem_col_din), 64'(ve[DATA_W-1:0]));
            end
        end
        if (mem_row_we === 1'b1) begin
            if (row_q.size() == 0) check("row_unexpected_write", 64'(1), 64'(0));
            else begin
                re = row_q.pop_front();
                check("row_wr_addr", 64'(mem_row_addr), 64'(re[ROW_W+DATA_W-1 -: ROW_W]));
                check("row_wr_din",  64'(mem_row_din),  64'(re[DATA_W-1:0]));
            end
        end

        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ld_start = 0; ld_valid = 0; ld_kind = 0; ld_last = 0;
        ld_val = '0; ld_col = '0;
        eng_done = 0; eng_rerun = 0;
    endtask

    task automatic beat(input bit kind, input logic [DATA_W-1:0] v,
                        input logic [DATA_W-1:0] c, input bit last);
        ld_valid = 1; ld_kind = kind; ld_val = v; ld_col = c; ld_last = last;
        tick();
        ld_valid = 0; ld_last = 0;
    endtask

    task automatic pulse_start();
        ld_start = 1; tick(); ld_start = 0;
    endtask

    task automatic pulse_done();
        eng_done = 1; tick(); eng_done = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        eng_vc_addr = '0; eng_row_addr = '0;
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        tick();                         // reset state
        reset = 0;
        tick();                         // idle: no ready, no writes

        // Basic load: three nonzeros and two row pointers.
        pulse_start();
        beat(0, 32'h11, 32'd0, 0);
        beat(0, 32'h22, 32'd5, 0);
        beat(0, 32'h33, 32'd9, 0);
        beat(1, 32'd0,  32'd0, 0);
        beat(1, 32'd3,  32'd0, 1);
        tick();                         // first COMPUTE cycle, eng_start pulse

        // Engine address mux, done, re-run.
        eng_vc_addr = 14'h1234; eng_row_addr = 10'h03A;
        tick();
        pulse_done();
        tick();
        eng_rerun = 1; tick(); eng_rerun = 0;
        tick();
        pulse_done();

        // Reload with ld_valid toggling every cycle.
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            ld_valid = (i % 2 == 0);
            ld_kind  = (i >= 6);
            ld_val   = 32'h100 + 32'(i);
            ld_col   = 32'(i);
            ld_last  = (i == 7);        // ignored: no beat in that cycle
            tick();
        end
        ld_last = 0;
        beat(1, 32'h7, 32'h0, 1);
        pulse_done();

        // Overflow: six nonzero beats into a four-entry RAM.
        pulse_start();
        for (int i = 0; i < 6; i++) beat(0, 32'hA0 + 32'(i), 32'(i), i == 5);
        tick();
        pulse_done();
        pulse_start();                  // clears err_overflow
        beat(1, 32'h1, 32'h0, 1);
        pulse_done();

        // ld_start and eng_rerun together: the load wins.
        ld_start = 1; eng_rerun = 1; tick();
        ld_start = 0; eng_rerun = 0;
        tick();

        // Reset in the middle of a load, then beats without ld_start.
        beat(0, 32'h55, 32'h1, 0);
        beat(0, 32'h66, 32'h2, 0);
        reset = 1; tick(); reset = 0;
        beat(0, 32'h77, 32'h3, 0);
        beat(1, 32'h88, 32'h0, 1);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            ld_start     = ($urandom_range(0, 9) == 0);
            ld_valid     = $urandom_range(0, 1);
            ld_kind      = $urandom_range(0, 1);
            ld_last      = ($urandom_range(0, 7) == 0);
            ld_val       = $urandom;
            ld_col       = $urandom;
            eng_vc_addr  = ADDR_W'($urandom);
            eng_row_addr = ROW_W'($urandom);
            eng_done     = ($urandom_range(0, 5) == 0);
            eng_rerun    = ($urandom_range(0, 4) == 0);
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();

        check("vc_queue_drained",  64'(vc_q.size()),  64'(0));
        check("row_queue_drained", 64'(row_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_load_phase_ctrl.md
Name: csr_load_phase_ctrl

Overview:
- Phase controller for the CSR sparse-matrix datapath. It owns the value, column and row-pointer RAM ports.
- During LOAD it writes an incoming matrix stream into those RAMs. During COMPUTE it hands RAM addresses to the multiply engine and forces all write enables low.
- It is the parametrised successor of the fixed done-based port mux. It adds a handshaked load stream, per-RAM fill counters, overflow detection, reload and re-run without reset.

Parameters:
- DATA_W, 32, width of value, column and row-pointer words
- ADDR_W, 14, value/column RAM address width
- ROW_W, 10, row-pointer RAM address width
- NNZ_DEPTH, 16384, usable value/column entries; must be ≤ 2^ADDR_W
- ROW_DEPTH, 1024, usable row-pointer entries; must be ≤ 2^ROW_W

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ld_start  in  1  request to load a new matrix
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid & ld_ready
- ld_kind  in  1  0 = nonzero entry (value + column), 1 = row pointer
- ld_val  in  DATA_W  value word (kind 0) or row pointer (kind 1)
- ld_col  in  DATA_W  column index (kind 0 only)
- ld_last  in  1  final beat of the matrix
- eng_vc_addr  in  ADDR_W  engine value/column read address
- eng_row_addr  in  ROW_W  engine row-pointer read address
- eng_done  in  1  engine finished pass
- eng_rerun  in  1  request another pass on the stored matrix
- eng_start  out  1  one-cycle engine start pulse
- mem_vc_addr  out  ADDR_W  shared value/column RAM address
- mem_vc_we  out  1  value/column write enable
- mem_val_din  out  DATA_W  value RAM write data
- mem_col_din  out  DATA_W  column RAM write data
- mem_row_addr  out  ROW_W  row-pointer RAM address
- mem_row_we  out  1  row-pointer write enable
- mem_row_din  out  DATA_W  row-pointer write data
- nnz_count  out  ADDR_W+1  nonzero entries stored
- row_count  out  ROW_W+1  row pointers stored
- phase  out  2  IDLE=0, LOAD=1, COMPUTE=2, DONE=3
- done  out  1  high while phase==DONE
- err_overflow  out  1  sticky; a beat was dropped for lack of capacity

Behaviour:
- Reset values: phase=IDLE, all counters 0, err_overflow=0, eng_start=0, done=0.
  - With phase=IDLE, ld_ready and both write enables are 0 combinationally.
- IDLE:
  - ld_start → LOAD on the next cycle.
  - On that transition, clear nnz_count, row_count and err_overflow.
- LOAD:
  - ld_ready=1.
  - Accepted kind-0 beat: mem_vc_we=1 in the same cycle, mem_vc_addr=nnz_count[ADDR_W-1:0], mem_val_din=ld_val, mem_col_din=ld_col. nnz_count increments.
  - Accepted kind-1 beat: same pattern on the row RAM using row_count.
  - Write enables are combinational from beat acceptance; data is passed through unregistered.
- Capacity:
  - Kind-0 beat with nnz_count==NNZ_DEPTH is accepted but not written, and the counter holds.
  - Kind-1 beat with row_count==ROW_DEPTH is accepted but not written, and the counter holds.
  - Either case sets err_overflow=1 the next cycle, and it stays set until the next IDLE/DONE→LOAD transition or reset.
- ld_last on an accepted beat:
  - That beat is written normally.
  - Next cycle phase=COMPUTE and eng_start=1 for exactly that one cycle.
- ld_valid=0 in LOAD: no write; ld_last is ignored unless the beat is accepted.
- COMPUTE:
  - Write enables are forced 0.
  - mem_vc_addr=eng_vc_addr and mem_row_addr=eng_row_addr, combinational.
  - eng_done → DONE next cycle. eng_done coinciding with the eng_start cycle is honoured.
- DONE:
  - done=1; addresses stay muxed to the engine; write enables stay 0.
  - ld_start → LOAD, with counters cleared.
  - eng_rerun → COMPUTE with an eng_start pulse in the first COMPUTE cycle. The stored matrix is untouched.
  - ld_start and eng_rerun together: ld_start wins.
- Inputs ignored outside their states:
  - ld_start in LOAD or COMPUTE.
  - eng_done in IDLE, LOAD or DONE.
  - eng_rerun outside DONE.
- Address mux: in IDLE and LOAD the RAM addresses come from the counters.
- Reset mid-operation: next cycle phase=IDLE with all outputs at reset values. A partially loaded matrix is abandoned; RAM contents are undefined to consumers.

Test Plan:
- Reset, ld_start, 3 kind-0 beats (val 0x11/0x22/0x33, col 0/5/9), then 2 kind-1 beats (0, 3) with ld_last on the last → mem_vc_we pulses at addrs 0,1,2; mem_row_we at 0,1; nnz_count=3, row_count=2; eng_start single pulse one cycle after last beat; phase=2.
- ld_valid toggled 1/0 every cycle during load → writes only on accepted cycles; addresses contiguous, no gaps.
- COMPUTE with eng_vc_addr=0x1234, eng_row_addr=0x3A → mem addrs follow same cycle, we=0; eng_done → done=1 next cycle; eng_rerun → phase=2 with eng_start pulse; nnz_count still 3.
- NNZ_DEPTH=4, send 6 kind-0 beats → 4 writes, nnz_count=4, err_overflow=1 after 5th beat; next ld_start from DONE clears it.
- ld_start and eng_rerun together in DONE → phase=LOAD, counters 0, no eng_start.
- reset asserted mid-LOAD after 2 beats → next cycle phase=0, counters 0, ld_ready=0, we=0; subsequent ld_valid has no effect until ld_start.
